// File: rtl/barrido_display.sv
// barrido_display
// ---------------
// Time-multiplexed display scan controller. It steps a 3-bit digit index
// through the active digits and presents the matching nibble of a
// frame-coherent display word. Each digit slot begins with a blanking
// interval so the previous digit's data never shows on the next enable.
// The 3-to-8 one-hot decoder that follows this block is purely combinational.
//
// Parameters:
//   DIV_ESCANEO - clock cycles per digit slot (blank + show), > BLANCO
//   BLANCO      - blank cycles at the start of each slot, >= 1
//   NUM_DIG     - number of active digits, 1..8
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  asynchronous active-high reset
//   habilita in   1  scan enable
//   carga    in   1  load strobe, captures dato into the shadow register
//   dato     in  32  display word, nibble k = dato[4k+3:4k]
//   sel      out  3  current digit index (decoder input)
//   digito   out  4  nibble of the displayed word for digit sel
//   valido   out  1  1 = digit lit, 0 = blank
//
// Optional build macro:
//   SUPRIME_CEROS_EN - leading-zero suppression. A digit above digit 0 whose
//                      nibble and all higher active nibbles are zero keeps
//                      valido low during its show phase.

module barrido_display #(
    parameter int DIV_ESCANEO = 50000,
    parameter int BLANCO      = 16,
    parameter int NUM_DIG     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        habilita,
    input  logic        carga,
    input  logic [31:0] dato,
    output logic [2:0]  sel,
    output logic [3:0]  digito,
    output logic        valido
);

    localparam int CW = (DIV_ESCANEO > 1) ? $clog2(DIV_ESCANEO) : 1;

    localparam logic [CW-1:0] CNT_FIN_BLANCO = CW'(BLANCO - 1);
    localparam logic [CW-1:0] CNT_FIN_SLOT   = CW'(DIV_ESCANEO - 1);
    localparam logic [2:0]    SEL_ULTIMO     = 3'(NUM_DIG - 1);

    typedef enum logic [1:0] {
        ST_REPOSO  = 2'd0,
        ST_BLANCO  = 2'd1,
        ST_MOSTRAR = 2'd2
    } estado_t;

    estado_t        estado, estado_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [2:0]     sel_n;
    logic [31:0]    sombra;
    logic [31:0]    activo, activo_n;
    logic [7:0][3:0] nib_n;
    logic           frontera;
    logic [3:0]     digito_n;
    logic           valido_n;

`ifdef SUPRIME_CEROS_EN
    logic [7:0]     mascara, mascara_n;
    logic           cero_alto;
`endif

    // Next-state, counter and index logic
    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        sel_n    = sel;
        frontera = 1'b0;

        unique case (estado)
            ST_REPOSO: begin
                cnt_n = '0;
                sel_n = '0;
                if (habilita) begin
                    estado_n = ST_BLANCO;
                    frontera = 1'b1;
                end
            end

            ST_BLANCO: begin
                if (!habilita) begin
                    estado_n = ST_REPOSO;
                    cnt_n    = '0;
                    sel_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_FIN_BLANCO)
                        estado_n = ST_MOSTRAR;
                end
            end

            ST_MOSTRAR: begin
                if (!habilita) begin
                    estado_n = ST_REPOSO;
                    cnt_n    = '0;
                    sel_n    = '0;
                end else if (cnt == CNT_FIN_SLOT) begin
                    estado_n = ST_BLANCO;
                    cnt_n    = '0;
                    if (sel == SEL_ULTIMO) begin
                        sel_n    = '0;
                        frontera = 1'b1;
                    end else begin
                        sel_n = sel + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                estado_n = ST_REPOSO;
                cnt_n    = '0;
                sel_n    = '0;
            end
        endcase
    end

    // Frame-boundary word update; a load on the boundary edge bypasses the
    // shadow register so the freshly loaded word is shown at once.
    always_comb begin
        activo_n = activo;
        if (frontera)
            activo_n = carga ? dato : sombra;
        nib_n    = activo_n;
        digito_n = nib_n[sel_n];
    end

`ifdef SUPRIME_CEROS_EN
    // Scan nibbles from the top active digit downwards; a digit is suppressed
    // while every nibble from it upwards is zero. Digit 0 is never suppressed.
    always_comb begin
        mascara_n = '0;
        cero_alto = 1'b1;
        for (int unsigned i = 0; i < NUM_DIG; i++) begin
            if (nib_n[3'(NUM_DIG - 1 - i)] != 4'd0)
                cero_alto = 1'b0;
            if (i != NUM_DIG - 1)
                mascara_n[3'(NUM_DIG - 1 - i)] = cero_alto;
        end
        valido_n = (estado_n == ST_MOSTRAR) && !mascara[sel_n];
    end
`else
    always_comb begin
        valido_n = (estado_n == ST_MOSTRAR);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= ST_REPOSO;
            cnt    <= '0;
            sel    <= '0;
            digito <= '0;
            valido <= 1'b0;
            sombra <= '0;
            activo <= '0;
        end else begin
            estado <= estado_n;
            cnt    <= cnt_n;
            sel    <= sel_n;
            digito <= digito_n;
            valido <= valido_n;
            activo <= activo_n;
            if (carga)
                sombra <= dato;
        end
    end

`ifdef SUPRIME_CEROS_EN
    // The mask settles at the boundary edge, at least one blank cycle before
    // any show phase reads it, so valido sees no extra latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mascara <= '0;
        else if (frontera)
            mascara <= mascara_n;
    end
`endif

endmodule
